// File: rtl/gpu_mtrx_pkg.sv
// Shared constants for the output-matrix path: fixed-point format, FSM state codes
// and the helper that selects one {X,Y,Z,W} point from a packed 4-point matrix.
package gpu_mtrx_pkg;

  localparam logic [15:0] W_ONE     = 16'h0020;
  localparam int          FRAC_BITS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  localparam int PT_BITS = 64;
  localparam int X_LSB   = 48;
  localparam int Y_LSB   = 32;
  localparam int Z_LSB   = 16;
  localparam int W_LSB   = 0;

  // Point 0 sits in the most significant 64 bits.
  function automatic logic [PT_BITS-1:0] pt_slice(input logic [4*PT_BITS-1:0] m,
                                                  input logic [1:0]           idx);
    case (idx)
      2'd0:    return m[4*PT_BITS-1 -: PT_BITS];
      2'd1:    return m[3*PT_BITS-1 -: PT_BITS];
      2'd2:    return m[2*PT_BITS-1 -: PT_BITS];
      default: return m[PT_BITS-1   -: PT_BITS];
    endcase
  endfunction

endpackage

// File: rtl/fxp_div_seq.sv
// Sequential radix-2 restoring divider computing sat16((num <<< FRAC_BITS) / den),
// truncated toward zero. done is high in the cycle whose clock edge retires the last bit.
module fxp_div_seq #(
  parameter int FRAC_BITS = gpu_mtrx_pkg::FRAC_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num,
  input  logic [15:0] den,
  output logic        done,
  output logic [15:0] quo
);

  localparam int N  = 16 + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [16:0]   rem;
  logic [N-1:0]  sh;
  logic [15:0]   dvs;
  logic          neg;

  logic [15:0]   num_abs, den_abs;
  logic [17:0]   shifted, diff;
  logic          ge;
  logic [16:0]   rem_n;
  logic [N-1:0]  sh_n;

  assign num_abs = num[15] ? 16'h0 - num : num;
  assign den_abs = den[15] ? 16'h0 - den : den;

  // sh holds the remaining dividend bits at the top and shifts quotient bits in below.
  assign shifted = {rem, sh[N-1]};
  assign diff    = shifted - {2'b00, dvs};
  assign ge      = ~diff[17];
  assign rem_n   = ge ? diff[16:0] : shifted[16:0];
  assign sh_n    = {sh[N-2:0], ge};

  assign done = busy && (cnt == CW'(1));

  always_comb begin
    // NOTE: default first so every path assigns quo and no latch is inferred.
    quo = sh_n[15:0];
    if (neg) begin
      if (sh_n > N'(32768)) quo = 16'h8000;
      else                  quo = 16'h0 - sh_n[15:0];
    end else if (sh_n > N'(32767)) begin
      quo = 16'h7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      sh   <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(N);
      rem  <= '0;
      sh   <= {num_abs, {FRAC_BITS{1'b0}}};
      dvs  <= den_abs;
      neg  <= num[15] ^ den[15];
    end else if (busy) begin
      rem  <= rem_n;
      sh   <= sh_n;
      cnt  <= cnt - CW'(1);
      busy <= (cnt != CW'(1));
    end
  end

endmodule

// File: rtl/output_matrix_unpack.sv
// Unpacks a 4-point {X,Y,Z,W} matrix into a point stream with valid/ready handshake.
// Define OUTPUT_MATRIX_WDIV_EN to divide X, Y, Z by W (perspective normalisation).
module output_matrix_unpack #(
  parameter logic [15:0] W_ONE     = gpu_mtrx_pkg::W_ONE,
  parameter int          FRAC_BITS = gpu_mtrx_pkg::FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mtrxValid,
  output logic         mtrxReady,
  input  logic [255:0] outMtrx,
  output logic [15:0]  poX,
  output logic [15:0]  poY,
  output logic [15:0]  poZ,
  output logic [1:0]   poIdx,
  output logic         poLast,
  output logic         poWErr,
  output logic         poValid,
  input  logic         poReady
);

  import gpu_mtrx_pkg::*;

  if (W_ONE != 16'(1 << FRAC_BITS)) begin : g_bad_w_one
    $error("output_matrix_unpack: W_ONE must equal 1 << FRAC_BITS");
  end

  logic [1:0]   state, idx, nxt_idx;
  logic [255:0] hold;
  logic [63:0]  nxt_pt;
  logic         accept, handshake, load_pt;

  assign mtrxReady = (state == ST_IDLE);
  assign poValid   = (state == ST_EMIT);
  assign poIdx     = idx;
  assign poLast    = (idx == 2'd3);

  assign accept    = mtrxValid && mtrxReady;
  assign handshake = poValid && poReady;
  assign load_pt   = accept || (handshake && idx != 2'd3);

  // Point 0 comes straight from the input since hold is written on the same edge.
  assign nxt_idx = mtrxReady ? 2'd0 : idx + 2'd1;
  assign nxt_pt  = mtrxReady ? outMtrx[255:192] : pt_slice(hold, nxt_idx);

`ifdef OUTPUT_MATRIX_WDIV_EN
  logic [15:0] w_q;
  logic [1:0]  sel;
  logic        div_start, div_done;
  logic [15:0] div_num, div_den, div_quo;

  // X starts on the load edge; Y and Z start on the edge that retires the previous one.
  always_comb begin
    div_start = 1'b0;
    div_num   = nxt_pt[X_LSB +: 16];
    div_den   = nxt_pt[W_LSB +: 16];
    if (load_pt) begin
      div_start = (nxt_pt[W_LSB +: 16] != 16'h0);
    end else if (state == ST_DIV && div_done && sel != 2'd2) begin
      div_start = 1'b1;
      div_num   = (sel == 2'd0) ? poY : poZ;
      div_den   = w_q;
    end
  end

  fxp_div_seq #(.FRAC_BITS(FRAC_BITS)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quo   (div_quo)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      // NOTE: hold is reset too, so nothing left over from an aborted matrix can leak out.
      hold   <= '0;
      poX    <= '0;
      poY    <= '0;
      poZ    <= '0;
      poWErr <= 1'b0;
`ifdef OUTPUT_MATRIX_WDIV_EN
      w_q    <= '0;
      sel    <= 2'd0;
`endif
    end else begin
      if (accept) hold <= outMtrx;
      // Raw coordinates are loaded first; the divider overwrites them when W != 0.
      if (load_pt) begin
        idx    <= nxt_idx;
        poX    <= nxt_pt[X_LSB +: 16];
        poY    <= nxt_pt[Y_LSB +: 16];
        poZ    <= nxt_pt[Z_LSB +: 16];
        poWErr <= (nxt_pt[W_LSB +: 16] == 16'h0);
`ifdef OUTPUT_MATRIX_WDIV_EN
        w_q    <= nxt_pt[W_LSB +: 16];
        sel    <= 2'd0;
        state  <= ST_DIV;
`else
        state  <= ST_EMIT;
`endif
      end else if (handshake) begin
        state <= ST_IDLE;
`ifdef OUTPUT_MATRIX_WDIV_EN
      end else if (state == ST_DIV) begin
        if (w_q == 16'h0) begin
          state <= ST_EMIT;
        end else if (div_done) begin
          case (sel)
            2'd0: begin poX <= div_quo; sel <= 2'd1; end
            2'd1: begin poY <= div_quo; sel <= 2'd2; end
            default: begin
              poZ   <= div_quo;
              sel   <= 2'd0;
              state <= ST_EMIT;
            end
          endcase
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_output_matrix_unpack.sv
// Randomised self-checking bench for output_matrix_unpack against a plain-arithmetic
// model; follows OUTPUT_MATRIX_WDIV_EN to choose divide or pass-through expectations.
`timescale 1ns/1ps
module tb_output_matrix_unpack;

  localparam int FRAC = 5;
`ifdef OUTPUT_MATRIX_WDIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         mtrxValid;
  logic         mtrxReady;
  logic [255:0] outMtrx;
  logic [15:0]  poX, poY, poZ;
  logic [1:0]   poIdx;
  logic         poLast, poWErr, poValid, poReady;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_matrix_unpack dut (
    .clk       (clk),
    .rst       (rst),
    .mtrxValid (mtrxValid),
    .mtrxReady (mtrxReady),
    .outMtrx   (outMtrx),
    .poX       (poX),
    .poY       (poY),
    .poZ       (poZ),
    .poIdx     (poIdx),
    .poLast    (poLast),
    .poWErr    (poWErr),
    .poValid   (poValid),
    .poReady   (poReady)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pt(input logic [15:0] x, input logic [15:0] y,
                                     input logic [15:0] z, input logic [15:0] w);
    return {x, y, z, w};
  endfunction

  // Reference: (c * 2^FRAC) / W truncated toward zero, clamped to int16.
  function automatic logic [15:0] model_coord(input logic [15:0] c, input logic [15:0] w);
    longint q;
    if (!DIV_EN || w == 16'h0) return c;
    q = (longint'($signed(c)) * (longint'(1) << FRAC)) / longint'($signed(w));
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return 16'(q);
  endfunction

  function automatic int exp_lat(input logic [15:0] w);
    if (!DIV_EN)     return 0;
    if (w == 16'h0)  return 1;
    return 3 * (16 + FRAC);
  endfunction

  function automatic logic [15:0] rand_w();
    case ($urandom_range(0, 7))
      0:       return 16'h0;
      1:       return 16'h0020;
      2, 3:    return 16'($urandom_range(1, 64));
      4:       return 16'h0 - 16'($urandom_range(1, 300));
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic show_idle_zero(input string tag);
    check({tag, "_valid"}, poValid, 0);
    check({tag, "_x"}, poX, 0);
    check({tag, "_y"}, poY, 0);
    check({tag, "_z"}, poZ, 0);
    check({tag, "_idx"}, poIdx, 0);
    check({tag, "_last"}, poLast, 0);
    check({tag, "_werr"}, poWErr, 0);
    check({tag, "_ready"}, mtrxReady, 1);
  endtask

  task automatic send(input logic [255:0] m);
    int k = 0;
    while (!mtrxReady && k < 300) begin
      step();
      k++;
    end
    check("send_ready", mtrxReady, 1);
    mtrxValid = 1'b1;
    outMtrx   = m;
    step();
    mtrxValid = 1'b0;
  endtask

  // Walks the beats of matrix m; optionally stalls one beat, drives ignored mtrxValid
  // traffic, or stops once beat stop_beat is presented.
  task automatic collect(input logic [255:0] m, input int stall_beat, input int stall_len,
                         input bit noise, input int stop_beat);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] p;
      logic [15:0] ex, ey, ez, w;
      int k;
      p  = m[255 - 64*i -: 64];
      w  = p[15:0];
      ex = model_coord(p[63:48], w);
      ey = model_coord(p[47:32], w);
      ez = model_coord(p[31:16], w);
      mtrxValid = noise && (i < 3);
      if (noise) outMtrx = {8{$urandom()}};
      k = 0;
      while (!poValid && k < 300) begin
        step();
        k++;
      end
      check($sformatf("beat%0d_latency", i), k, exp_lat(w));
      if (!poValid) begin
        mtrxValid = 1'b0;
        return;
      end
      check($sformatf("beat%0d_mready", i), mtrxReady, 0);
      check($sformatf("beat%0d_x", i), poX, ex);
      check($sformatf("beat%0d_y", i), poY, ey);
      check($sformatf("beat%0d_z", i), poZ, ez);
      check($sformatf("beat%0d_idx", i), poIdx, i);
      check($sformatf("beat%0d_last", i), poLast, (i == 3));
      check($sformatf("beat%0d_werr", i), poWErr, (w == 16'h0));
      if (i == stop_beat) begin
        mtrxValid = 1'b0;
        return;
      end
      if (i == stall_beat) begin
        poReady = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          step();
          check($sformatf("stall%0d_valid", i), poValid, 1);
          check($sformatf("stall%0d_x", i), poX, ex);
          check($sformatf("stall%0d_y", i), poY, ey);
          check($sformatf("stall%0d_z", i), poZ, ez);
          check($sformatf("stall%0d_idx", i), poIdx, i);
        end
        poReady = 1'b1;
      end
      step();
    end
    mtrxValid = 1'b0;
    check("end_valid", poValid, 0);
    check("end_ready", mtrxReady, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] m;
    rst       = 1'b1;
    mtrxValid = 1'b0;
    outMtrx   = '0;
    poReady   = 1'b1;
    repeat (3) step();
    show_idle_zero("reset");
    rst = 1'b0;
    step();
    check("post_reset_ready", mtrxReady, 1);

    // Pass-through set, unity W, full-rate handshake.
    m = {pt(16'h0020, 16'h0040, 16'h0060, 16'h0020), pt(16'h0001, 16'h0002, 16'h0003, 16'h0020),
         pt(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h0020), pt(16'h7FFF, 16'h0000, 16'h8000, 16'h0020)};
    send(m);
    collect(m, -1, 0, 1'b0, 4);

    // Back-pressure on beat 1, with ignored mtrxValid traffic while busy.
    send(m);
    collect(m, 1, 5, 1'b1, 4);

    // Division set.
    m = {pt(16'h0040, 16'hFFC0, 16'h0010, 16'h0040), pt(16'h0100, 16'h0200, 16'hFF00, 16'h0020),
         pt(16'h1234, 16'h0001, 16'hFFFF, 16'h0003), pt(16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF)};
    send(m);
    collect(m, -1, 0, 1'b0, 4);

    // Saturation set.
    m = {pt(16'h7FFF, 16'h0001, 16'h0002, 16'h0001), pt(16'h8000, 16'h0003, 16'h0004, 16'h0001),
         pt(16'h4000, 16'hC000, 16'h0001, 16'h0002), pt(16'h0005, 16'h0006, 16'h0007, 16'h0020)};
    send(m);
    collect(m, -1, 0, 1'b0, 4);

    // W = 0 on point 2 only.
    m = {pt(16'h0011, 16'h0022, 16'h0033, 16'h0020), pt(16'h0044, 16'h0055, 16'h0066, 16'h0020),
         pt(16'h0077, 16'h0088, 16'h0099, 16'h0000), pt(16'h00AA, 16'h00BB, 16'h00CC, 16'h0020)};
    send(m);
    collect(m, 2, 2, 1'b0, 4);

    // Randomised matrices with random stalls and ignored input traffic.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        m[255 - 64*k -: 64] = pt(16'($urandom()), 16'($urandom()), 16'($urandom()), rand_w());
      send(m);
      collect(m, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4);
    end

    // Reset while beat 2 is presented; the next matrix must start at point 0.
    send(m);
    collect(m, -1, 0, 1'b0, 2);
    rst = 1'b1;
    step();
    show_idle_zero("midrst");
    step();
    rst = 1'b0;
    check("midrst_ready_first", mtrxReady, 1);
    repeat (3) begin
      step();
      check("midrst_no_beat", poValid, 0);
    end
    m = {pt(16'h0101, 16'h0202, 16'h0303, 16'h0020), pt(16'h0404, 16'h0505, 16'h0606, 16'h0040),
         pt(16'h0707, 16'h0808, 16'h0909, 16'h0010), pt(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0020)};
    send(m);
    collect(m, -1, 0, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
